// File: rtl/rotary_quad_decoder.sv
`timescale 1ns/1ps
// Quadrature encoder front end: two-flop synchronizers, optional debounce, step decode, signed position.
// Define ROTDEC_DEBOUNCE_EN to include the per-channel debounce filters (DEBOUNCE_CYCLES stable cycles).

module rotary_quad_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int POS_W           = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    a_in,
    input  logic                    b_in,
    input  logic                    pos_clr,
    input  logic                    err_clr,
    output logic                    cw_out,
    output logic                    ccw_out,
    output logic                    err_pulse,
    output logic                    err_sticky,
    output logic signed [POS_W-1:0] pos_out
);

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 255) || (POS_W < 8) || (POS_W > 32)) begin : g_param_check
        $error("rotary_quad_decoder: DEBOUNCE_CYCLES or POS_W out of range");
    end

    // Next code in the clockwise / counter-clockwise Gray sequence, as {A,B}.
    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ccw_next(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_settle_cnt;
    logic [1:0]         w_settle_cnt_nxt;
    logic               w_run;

    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_filt;
    logic [1:0]         r_prev;

    logic               w_step_cw;
    logic               w_step_ccw;
    logic               w_illegal;

    logic               r_cw;
    logic               r_ccw;
    logic               r_err;
    logic               r_sticky;
    logic signed [POS_W-1:0] r_pos;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= SETTLE;
            r_settle_cnt <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no inferred latch).
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_run            = 1'b0;
        case (r_state)
            SETTLE: begin
                w_settle_cnt_nxt = r_settle_cnt + 2'd1;
                if (r_settle_cnt == 2'd3) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Input synchronizers, {A,B}
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {a_in, b_in};
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Channel filters
    // ------------------------------------------------------------------
`ifdef ROTDEC_DEBOUNCE_EN
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] r_samp;
    logic [7:0] r_cnt [2];

    // The sample stage keeps the debounce comparison off the synchronizer output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_samp   <= 2'b00;
            r_filt   <= 2'b00;
            // NOTE: the counter array is only two entries, so it is reset like ordinary flops.
            r_cnt[0] <= 8'd0;
            r_cnt[1] <= 8'd0;
        end else begin
            r_samp <= r_sync2;
            if (!w_run) begin
                r_filt   <= r_sync2;
                r_cnt[0] <= 8'd0;
                r_cnt[1] <= 8'd0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (r_samp[i] == r_filt[i]) begin
                        r_cnt[i] <= 8'd0;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        r_filt[i] <= r_samp[i];
                        r_cnt[i]  <= 8'd0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= 2'b00;
        end else begin
            r_filt <= r_sync2;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Step decoder and position counter
    // ------------------------------------------------------------------
    assign w_step_cw  = (r_filt == cw_next(r_prev));
    assign w_step_ccw = (r_filt == ccw_next(r_prev));
    assign w_illegal  = ((r_filt ^ r_prev) == 2'b11);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev   <= 2'b00;
            r_cw     <= 1'b0;
            r_ccw    <= 1'b0;
            r_err    <= 1'b0;
            r_sticky <= 1'b0;
            r_pos    <= '0;
        end else begin
            r_prev <= r_filt;
            if (w_run) begin
                r_cw  <= w_step_cw;
                r_ccw <= w_step_ccw;
                r_err <= w_illegal;
                // A clear wins over a coincident step; the step pulse is still issued.
                if (pos_clr) begin
                    r_pos <= '0;
                end else if (w_step_cw) begin
                    r_pos <= r_pos + POS_W'(1);
                end else if (w_step_ccw) begin
                    r_pos <= r_pos - POS_W'(1);
                end
                if (w_illegal) begin
                    r_sticky <= 1'b1;
                end else if (err_clr) begin
                    r_sticky <= 1'b0;
                end
            end else begin
                r_cw  <= 1'b0;
                r_ccw <= 1'b0;
                r_err <= 1'b0;
            end
        end
    end

    assign cw_out     = r_cw;
    assign ccw_out    = r_ccw;
    assign err_pulse  = r_err;
    assign err_sticky = r_sticky;
    assign pos_out    = r_pos;

endmodule

// File: tb/tb_rotary_quad_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench for rotary_quad_decoder: directed steps push expected pulses, a negedge monitor pops and compares.
// Follows ROTDEC_DEBOUNCE_EN to pick the matching latency and a position width that keeps the wrap test short.

module tb_rotary_quad_decoder;

`ifdef ROTDEC_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int W   = 8;
`else
    localparam bit DEB = 1'b0;
    localparam int W   = 16;
`endif
    localparam int N       = 16;
    localparam int LAT     = DEB ? N + 3 : 3;
    localparam int HOLD    = 40;
    localparam int FAST    = DEB ? N + 2 : 1;
    localparam int PARTIAL = DEB ? 8 : 1;

    localparam logic [W-1:0] POS_M2  = W'(-2);
    localparam logic [W-1:0] POS_M4  = W'(-4);
    localparam logic [W-1:0] POS_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};

    typedef struct {
        bit           cw;
        bit           ccw;
        bit           err;
        logic [W-1:0] pos;
        bit           sticky;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         a_in;
    logic         b_in;
    logic         pos_clr;
    logic         err_clr;
    logic         cw_out;
    logic         ccw_out;
    logic         err_pulse;
    logic         err_sticky;
    logic [W-1:0] pos_out;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc      = 0;
    logic [1:0]   m_ab;
    logic [W-1:0] m_pos;
    bit           m_sticky;

    rotary_quad_decoder #(
        .DEBOUNCE_CYCLES(N),
        .POS_W          (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_in      (a_in),
        .b_in      (b_in),
        .pos_clr   (pos_clr),
        .err_clr   (err_clr),
        .cw_out    (cw_out),
        .ccw_out   (ccw_out),
        .err_pulse (err_pulse),
        .err_sticky(err_sticky),
        .pos_out   (pos_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [1:0] cw_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ccw_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Monitor: every pulse must match the oldest expected event; overdue events are reported as missing.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL evt_missing: no pulse seen, expected at cycle %0d (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (cw_out || ccw_out || err_pulse) begin
            check("cw_ccw_exclusive", 32'(cw_out & ccw_out), 32'd0);
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL evt_unexpected: cw=%0b ccw=%0b err=%0b but none expected at cycle %0d",
                         cw_out, ccw_out, err_pulse, cyc);
            end else begin
                e = q.pop_front();
                check("evt_kind", 32'({cw_out, ccw_out, err_pulse}), 32'({e.cw, e.ccw, e.err}));
                check("evt_pos", 32'(pos_out), 32'(e.pos));
                check("evt_sticky", 32'(err_sticky), 32'(e.sticky));
                check("evt_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive a new {A,B} level at a negedge and hold it; optionally apply clears at the expected pulse edge.
    task automatic drive(input logic [1:0] ab, input int hold, input bit push,
                         input bit pclr = 1'b0, input bit eclr = 1'b0);
        int   c_exp;
        exp_t e;
        @(negedge clk);
        a_in  = ab[1];
        b_in  = ab[0];
        c_exp = cyc + 1 + LAT;
        if (push) begin
            e.cw  = (ab == cw_of(m_ab));
            e.ccw = (ab == ccw_of(m_ab));
            e.err = ((ab ^ m_ab) == 2'b11);
            if (pclr)       m_pos = '0;
            else if (e.cw)  m_pos = m_pos + W'(1);
            else if (e.ccw) m_pos = m_pos - W'(1);
            if (e.err)      m_sticky = 1'b1;
            else if (eclr)  m_sticky = 1'b0;
            e.pos    = m_pos;
            e.sticky = m_sticky;
            e.cyc    = c_exp;
            if (e.cw || e.ccw || e.err) q.push_back(e);
            m_ab = ab;
        end
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            if (cyc == c_exp - 1) begin
                pos_clr = pclr;
                err_clr = eclr;
            end else if (cyc == c_exp) begin
                pos_clr = 1'b0;
                err_clr = 1'b0;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < LAT + 10 && q.size() > 0; i++) @(negedge clk);
    endtask

    task automatic clear_pos();
        @(negedge clk);
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        m_pos   = '0;
        @(negedge clk);
        check("pos_after_clr", 32'(pos_out), 32'd0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr  = 1'b0;
        m_sticky = 1'b0;
        @(negedge clk);
        check("sticky_after_clr", 32'(err_sticky), 32'd0);
    endtask

    // Assert reset away from the clock edge, confirm outputs clear at once, hold inputs at ab through release.
    task automatic do_reset(input logic [1:0] ab);
        wait_drain();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_cw", 32'(cw_out), 32'd0);
        check("rst_ccw", 32'(ccw_out), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        check("rst_pos", 32'(pos_out), 32'd0);
        a_in = ab[1];
        b_in = ab[0];
        repeat (4) @(negedge clk);
        reset_n  = 1'b1;
        m_ab     = ab;
        m_pos    = '0;
        m_sticky = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        reset_n  = 1'b0;
        a_in     = 1'b0;
        b_in     = 1'b0;
        pos_clr  = 1'b0;
        err_clr  = 1'b0;
        m_ab     = 2'b00;
        m_pos    = '0;
        m_sticky = 1'b0;

        do_reset(2'b00);

        // Clockwise cycle
        drive(2'b01, HOLD, 1'b1);
        drive(2'b11, HOLD, 1'b1);
        drive(2'b10, HOLD, 1'b1);
        drive(2'b00, HOLD, 1'b1);
        wait_drain();
        check("cw_seq_pos", 32'(pos_out), 32'd4);

        // Counter-clockwise cycle from zero
        clear_pos();
        drive(2'b10, HOLD, 1'b1);
        drive(2'b11, HOLD, 1'b1);
        drive(2'b01, HOLD, 1'b1);
        drive(2'b00, HOLD, 1'b1);
        wait_drain();
        check("ccw_seq_pos", 32'(pos_out), 32'(POS_M4));

        // Bouncing A edge: only the final level is a step when debounce is present
        drive(2'b01, HOLD, 1'b1);
        drive(2'b11, 3, !DEB);
        drive(2'b01, 3, !DEB);
        drive(2'b11, 3, !DEB);
        drive(2'b01, 3, !DEB);
        drive(2'b11, HOLD, 1'b1);
        wait_drain();
        check("bounce_pos", 32'(pos_out), 32'(POS_M2));
        check("bounce_no_err", 32'(err_sticky), 32'd0);

        // Illegal diagonal transitions
        drive(2'b00, HOLD, 1'b1);
        wait_drain();
        check("illegal_sticky", 32'(err_sticky), 32'd1);
        check("illegal_pos_hold", 32'(pos_out), 32'(POS_M2));
        clear_err();
        drive(2'b11, HOLD, 1'b1, 1'b0, 1'b1);
        wait_drain();
        check("err_set_wins", 32'(err_sticky), 32'd1);
        clear_err();

        // Wrap at both ends of the signed range
        clear_pos();
        for (int i = 0; i < (1 << (W - 1)) - 1; i++) drive(cw_of(m_ab), FAST, 1'b1);
        wait_drain();
        check("preload_max", 32'(pos_out), 32'(POS_MAX));
        drive(cw_of(m_ab), HOLD, 1'b1);
        wait_drain();
        check("wrap_max_to_min", 32'(pos_out), 32'(POS_MIN));
        drive(ccw_of(m_ab), HOLD, 1'b1);
        wait_drain();
        check("wrap_min_to_max", 32'(pos_out), 32'(POS_MAX));
        drive(cw_of(m_ab), HOLD, 1'b1);
        drive(cw_of(m_ab), HOLD, 1'b1, 1'b1, 1'b0);
        wait_drain();
        check("pos_clr_with_step", 32'(pos_out), 32'd0);

        // Inputs at 11 through reset release: no settle pulse, prev starts at 11
        do_reset(2'b11);
        drive(2'b10, HOLD, 1'b1);
        wait_drain();
        check("post_settle_step", 32'(pos_out), 32'd1);

        // Reset in the middle of a pending transition discards it
        drive(2'b00, PARTIAL, 1'b0);
        do_reset(2'b00);
        repeat (LAT + 10) @(negedge clk);
        drive(2'b01, HOLD, 1'b1);
        wait_drain();
        check("post_partial_step", 32'(pos_out), 32'd1);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rotary_quad_decoder.md
ROTARY_QUAD_DECODER -- requirements
Module: rotary_quad_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, stable-cycle count N required before a filtered channel changes; legal range 2..255.
REQ-002 Parameter POS_W, default 16, width of the signed position counter; legal range 8..32.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 a_in  input  1  raw encoder channel A, asynchronous to clk, may bounce.
REQ-006 b_in  input  1  raw encoder channel B, asynchronous to clk, may bounce.
REQ-007 pos_clr  input  1  synchronous clear of pos_out, sampled each cycle.
REQ-008 err_clr  input  1  synchronous clear of err_sticky, sampled each cycle.
REQ-009 cw_out  output  1  one-cycle pulse per valid clockwise quadrature step.
REQ-010 ccw_out  output  1  one-cycle pulse per valid counter-clockwise quadrature step.
REQ-011 err_pulse  output  1  one-cycle pulse per illegal transition (both channels changed together).
REQ-012 err_sticky  output  1  set by any illegal transition, held until err_clr.
REQ-013 pos_out  output  POS_W  signed two's-complement step count, +1 per cw step, -1 per ccw step.

Function
REQ-014 a_in and b_in each SHALL pass through a two-flop synchronizer before any other use.
REQ-015 Per channel debounce: counter increments each cycle synchronized value differs from filtered value, clears to 0 when equal; filtered value takes synchronized value when counter = N-1 and values still differ, counter then clears.
REQ-016 Decoder SHALL hold prev = last filtered {A,B}; codes 00->01->11->10->00 are cw steps, the reverse sequence ccw steps.
REQ-017 Valid step SHALL register exactly one cw_out or ccw_out pulse; unchanged state produces no pulse; cw_out and ccw_out never high together.
REQ-018 Diagonal transition (00<->11, 01<->10) SHALL produce err_pulse, set err_sticky, no cw/ccw pulse, no pos_out change; prev still updates to new state.
REQ-019 Latency: pulse high for the cycle following the (N+3)th rising edge after the edge that first samples a new input level (debounce compiled in).
REQ-020 pos_out SHALL wrap modulo 2^POS_W (max positive +1 -> most negative, and reverse).
REQ-021 pos_clr coincident with a step: pos_out becomes 0, step not counted; cw/ccw pulse still issued.
REQ-022 err_clr coincident with illegal transition: err_sticky remains 1 (set wins); err_pulse still issued.
REQ-023 Control FSM states SETTLE and RUN; SETTLE lasts 4 cycles after reset release, filtered values load synchronized values directly, prev loads filtered, all pulses and pos/err updates suppressed; then RUN unconditionally.

Reset
REQ-024 Asserting reset_n low SHALL immediately clear synchronizers, filters, debounce counters, prev, pos_out, err_sticky, cw_out, ccw_out, err_pulse to 0 and force SETTLE.
REQ-025 Reset asserted mid-step or mid-debounce SHALL discard the partial count; no pulse issued for it after release.

Configuration
REQ-026 Macro ROTDEC_DEBOUNCE_EN defined: debounce filters per REQ-015, latency per REQ-019.
REQ-027 Macro ROTDEC_DEBOUNCE_EN undefined: filtered value equals synchronizer output directly, DEBOUNCE_CYCLES ignored, pulse high for cycle following the 3rd rising edge after first sampling edge; all other behaviour unchanged.

Verification
REQ-028 N=16, after SETTLE drive AB 00->01->11->10->00, each held 40 cycles -> four cw_out pulses, pos_out = 4, each pulse 19 cycles after its edge.
REQ-029 Same sequence reversed from pos_out=0 -> four ccw_out pulses, pos_out = -4 (0xFFFC at POS_W=16).
REQ-030 A toggles 5 times at 3-cycle spacing then settles high, N=16 -> exactly one cw_out pulse, no err_pulse.
REQ-031 AB 00->11 simultaneously -> one err_pulse, err_sticky=1, pos_out unchanged; err_clr pulse -> err_sticky=0.
REQ-032 Preload pos_out to 32767 via 32767 cw steps, one more cw step -> pos_out = -32768; pos_clr with next step -> pos_out = 0.
REQ-033 Inputs held at 11 through reset release -> no pulse during or after SETTLE; reset mid-debounce -> no pulse afterwards.
